sdp_ram_port_arbiter: RTL
=========================

// Module: sdp_ram_port_arbiter
// PURPOSE
//   Shares one simple dual-port RAM (1 sync write port, 1 sync read port, 1-cycle read latency)
//   between two client requesters. Write and read ports are arbitrated independently with
//   per-port round-robin, so one client's write and the other client's read can proceed in the same cycle.
//   Sits between the clients and the RAM; drives the RAM write/read address, data and enable pins.
// PARAMETERS
//   DATA_WIDTH  8  width of RAM word / client data
//   ADDR_WIDTH  7  RAM address width (depth 2**ADDR_WIDTH)
// PORTS
//   clk          in   1           single clock, all state on posedge
//   rst          in   1           synchronous, active-high reset
//   cN_req       in   1           client N (N=0,1) access request, held until cN_gnt
//   cN_we        in   1           1 = write request, 0 = read request; stable while cN_req
//   cN_addr      in   ADDR_WIDTH  access address
//   cN_wdata     in   DATA_WIDTH  write data
//   cN_gnt       out  1           request accepted this cycle (combinational)
//   cN_rvalid    out  1           read data for client N on cN_rdata this cycle (registered)
//   cN_rdata     out  DATA_WIDTH  read data (wired from ram_data_r)
//   ram_we       out  1           RAM write enable
//   ram_add_w    out  ADDR_WIDTH  RAM write address
//   ram_data_w   out  DATA_WIDTH  RAM write data
//   ram_add_r    out  ADDR_WIDTH  RAM read address
//   ram_data_r   in   DATA_WIDTH  RAM registered read data
// BEHAVIOUR
//   - Write candidates: cN_req & cN_we. Read candidates: cN_req & ~cN_we.
//   - Each port: 0 candidates -> no grant; 1 -> that client; 2 -> client at that port's rr pointer.
//   - rr_w / rr_r pointer (1 bit each): after a grant to client k, pointer <= ~k. No grant -> unchanged.
//   - At most one write grant and one read grant per cycle; a client gets at most one grant per cycle.
//   - Write grant to k: ram_we=1, ram_add_w=ck_addr, ram_data_w=ck_wdata in the same cycle. RAM
//     commits at that clock edge. No write grant: ram_we=0, ram_add_w/ram_data_w=0.
//   - Read grant to k in cycle T: ram_add_r=ck_addr in T; ck_rvalid=1 in T+1 only.
//     Latency = 1 cycle. No read grant: ram_add_r=0.
//   - cN_rdata = ram_data_r for both clients; valid only when cN_rvalid=1.
//   - A read and a write to the same address granted in the same cycle return OLD data (RAM
//     read-before-write); no forwarding.
//   - Back-to-back: a client holding req gets a grant every cycle if uncontested. Under contention,
//     grants strictly alternate 0,1,0,1...
//   - Reset (rst=1 at edge): rr_w=rr_r=0 (client 0 preferred), c0_rvalid=c1_rvalid=0.
//     While rst=1: all cN_gnt=0, ram_we=0, ram_add_w/ram_data_w/ram_add_r=0.
//     Reset during a read: the pending rvalid is dropped. A write granted in the cycle rst rises is
//     not issued, since rst gates ram_we.
//   - cN_rdata has no reset value; it reflects ram_data_r.
// TESTING
//   1 Reset: rst=1 for 2 cycles with c0/c1 requesting -> no gnt, ram_we=0, rvalid=0; after release
//     the first contended grant goes to c0.
//   2 Write then read: c0 write addr 5 data 0xA5; next cycle c0 read addr 5 -> c0_gnt both cycles;
//     c0_rvalid=1 one cycle after the read grant; c0_rdata=0xA5.
//   3 Write contention: c0 and c1 both write (addr 1/0x11, addr 2/0x22) held 4 cycles ->
//     grants alternate c0,c1,c0,c1; mem[1]=0x11, mem[2]=0x22.
//   4 Parallel ports: c0 writes addr 9 data 0x3C while c1 reads addr 9 (old value 0x00) same cycle ->
//     both granted; c1_rvalid next cycle with 0x00; c1 re-read returns 0x3C.
//   5 Read contention: both clients read addr 3 (0x77) continuously -> alternating grants;
//     exactly one rvalid per cycle to the matching client, data 0x77.
//   6 Reset mid-read: c1 read granted, rst=1 on next edge -> c1_rvalid stays 0; rr pointers back to 0.

Source files
------------

// File: rtl/sdp_ram_port_arbiter.sv
// Two-client front end for a simple dual-port RAM: the write port and the read port each
// have their own 2-way round-robin arbiter, so a write and a read can be granted in one cycle.

module sdp_ram_port_rr2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    gnt_o = 2'b00;
    if (!rst) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  // The pointer names the client preferred on the next tie: the one not just served.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o[0]) begin
      ptr_d = 1'b1;
    end else if (gnt_o[1]) begin
      ptr_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

module sdp_ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c0_req,
  input  logic                  c0_we,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [DATA_WIDTH-1:0] c0_wdata,
  output logic                  c0_gnt,
  output logic                  c0_rvalid,
  output logic [DATA_WIDTH-1:0] c0_rdata,
  input  logic                  c1_req,
  input  logic                  c1_we,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [DATA_WIDTH-1:0] c1_wdata,
  output logic                  c1_gnt,
  output logic                  c1_rvalid,
  output logic [DATA_WIDTH-1:0] c1_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_add_w,
  output logic [DATA_WIDTH-1:0] ram_data_w,
  output logic [ADDR_WIDTH-1:0] ram_add_r,
  input  logic [DATA_WIDTH-1:0] ram_data_r
);

  logic [1:0] wr_cand, rd_cand;
  logic [1:0] wr_gnt, rd_gnt;
  logic [1:0] rvalid_q, rvalid_d;

  assign wr_cand = {c1_req &  c1_we, c0_req &  c0_we};
  assign rd_cand = {c1_req & ~c1_we, c0_req & ~c0_we};

  sdp_ram_port_rr2 u_wr_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (wr_cand),
    .gnt_o (wr_gnt)
  );

  sdp_ram_port_rr2 u_rd_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (rd_cand),
    .gnt_o (rd_gnt)
  );

  // A client is either a write or a read candidate, never both, so OR-ing is one grant at most.
  assign c0_gnt = wr_gnt[0] | rd_gnt[0];
  assign c1_gnt = wr_gnt[1] | rd_gnt[1];

  always_comb begin
    ram_we     = 1'b0;
    ram_add_w  = '0;
    ram_data_w = '0;
    if (wr_gnt[0]) begin
      ram_we     = 1'b1;
      ram_add_w  = c0_addr;
      ram_data_w = c0_wdata;
    end else if (wr_gnt[1]) begin
      ram_we     = 1'b1;
      ram_add_w  = c1_addr;
      ram_data_w = c1_wdata;
    end
  end

  always_comb begin
    ram_add_r = '0;
    if (rd_gnt[0]) begin
      ram_add_r = c0_addr;
    end else if (rd_gnt[1]) begin
      ram_add_r = c1_addr;
    end
  end

  // Read grants are already masked by rst, so a read cannot straddle a reset edge.
  assign rvalid_d = rd_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 2'b00;
    end else begin
      rvalid_q <= rvalid_d;
    end
  end

  assign c0_rvalid = rvalid_q[0];
  assign c1_rvalid = rvalid_q[1];
  assign c0_rdata  = ram_data_r;
  assign c1_rdata  = ram_data_r;

endmodule
